// File: rtl/mips_int_pkg.sv
// Shared types and defaults for the MIPS interrupt controller.
// Optional build macro (used in irq_edge_sync): IRQ_SYNC_EN.
package mips_int_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } int_state_e;

   localparam logic [3:0] MASK_RST_DEF = 4'b0001;

   // Cause-index width; never narrower than one bit, even for a single line.
   function automatic int calc_cw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-line rising-edge detector with an optional 2-flop synchroniser in front.
// Build macro: IRQ_SYNC_EN adds the synchroniser (two extra cycles of latency).
module irq_edge_sync #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] irq_in,
   output logic [N-1:0] irq_edge
);

   logic [N-1:0] irq_s;
   logic [N-1:0] irq_q;

   for (genvar i = 0; i < N; i++) begin : g_line
`ifdef IRQ_SYNC_EN
      logic sync1, sync2;
      always_ff @(posedge clk) begin
         if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
         end else begin
            sync1 <= irq_in[i];
            sync2 <= sync1;
         end
      end
      assign irq_s[i] = sync2;
`else
      assign irq_s[i] = irq_in[i];
`endif

      // irq_q clears on reset, so a line held high through reset yields one edge.
      always_ff @(posedge clk) begin
         if (rst) irq_q[i] <= 1'b0;
         else     irq_q[i] <= irq_s[i];
      end

      assign irq_edge[i] = irq_s[i] & ~irq_q[i];
   end

endmodule

// File: rtl/mips_int_ctrl.sv
// Interrupt controller beside CP0: latches irq edges, masks/prioritises them and
// runs the req/ack/eret handshake with the exception stage. Build macro: IRQ_SYNC_EN.
module mips_int_ctrl
   import mips_int_pkg::*;
#(
   parameter int                 NUM_IRQ  = 4,
   parameter logic [NUM_IRQ-1:0] MASK_RST = NUM_IRQ'(MASK_RST_DEF),
   localparam int                CW       = calc_cw(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   output logic [NUM_IRQ-1:0] mask_rdata,
   output logic               int_req,
   output logic [CW-1:0]      int_cause,
   input  logic               int_ack,
   input  logic [31:0]        epc_in,
   output logic [31:0]        epc_out,
   input  logic               eret,
   output logic               int_active,
   output logic [NUM_IRQ-1:0] pending
);

   int_state_e         state;
   logic               ie;
   logic [NUM_IRQ-1:0] mask_q;
   logic [NUM_IRQ-1:0] irq_edge;
   logic [NUM_IRQ-1:0] clr_vec;
   logic [NUM_IRQ-1:0] pending_nxt;
   logic [NUM_IRQ-1:0] req_vec;
   logic               take_ack;

   irq_edge_sync #(.N(NUM_IRQ)) u_edge (
      .clk      (clk),
      .rst      (rst),
      .irq_in   (irq_in),
      .irq_edge (irq_edge)
   );

   // Index 0 is highest priority: scan downward so the lowest set bit wins.
   function automatic logic [CW-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
      lowest_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (v[i]) lowest_idx = CW'(i);
   endfunction

   assign take_ack = (state == REQ) && int_ack;
   assign req_vec  = pending & mask_q;

   always_comb begin
      clr_vec = '0;
      for (int i = 0; i < NUM_IRQ; i++)
         if (take_ack && (CW'(i) == int_cause)) clr_vec[i] = 1'b1;
   end

   // A new edge on the line being acknowledged survives the clear.
   assign pending_nxt = (pending & ~clr_vec) | irq_edge;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pending    <= '0;
         mask_q     <= MASK_RST;
         ie         <= 1'b1;
         int_req    <= 1'b0;
         int_cause  <= '0;
         epc_out    <= '0;
         int_active <= 1'b0;
      end else begin
         pending <= pending_nxt;
         if (mask_we) mask_q <= mask_wdata;

         case (state)
            IDLE: begin
               if (ie && |req_vec) begin
                  state     <= REQ;
                  int_req   <= 1'b1;
                  int_cause <= lowest_idx(req_vec);
               end
            end
            // Request is committed: mask writes here never withdraw it.
            REQ: begin
               if (int_ack) begin
                  state      <= SERVICE;
                  epc_out    <= epc_in;
                  ie         <= 1'b0;
                  int_req    <= 1'b0;
                  int_active <= 1'b1;
               end
            end
            SERVICE: begin
               if (eret) begin
                  state      <= IDLE;
                  ie         <= 1'b1;
                  int_active <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               int_req    <= 1'b0;
               int_active <= 1'b0;
               ie         <= 1'b1;
            end
         endcase
      end
   end

   assign mask_rdata = mask_q;

endmodule
